pulse_width_stats: RTL
======================

Name: pulse_width_stats

Overview:
- Downstream consumer of the pulse-width measurement stage.
- Samples each completed measurement (pulse_width qualified by pulse_done) and accumulates min, max and sum over a window of 2^WINDOW_LOG2 pulses.
- At window close, emits one statistics report (min/max/sum/avg) on a valid/ready handshake toward the register/telemetry layer.
- Tracks dropped reports and out-of-range pulses.

Parameters:
- WIDTH, 32, width of pulse_width samples and of min/max/avg fields.
- WINDOW_LOG2, 3, window size is 2^WINDOW_LOG2 samples (legal range 0..8).
- LIMIT_LO, 0, pulses with width < LIMIT_LO count as out-of-range.
- LIMIT_HI, 2^WIDTH-1, pulses with width > LIMIT_HI count as out-of-range.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- clear  in  1  synchronous flush of accumulators, report slot and flags
- enable  in  1  sample gate; pulse_done ignored while low
- pulse_width  in  WIDTH  measured width from the upstream detector
- pulse_done  in  1  one-cycle strobe; pulse_width is valid this cycle
- rpt_valid  out  1  report slot holds an unaccepted report
- rpt_ready  in  1  consumer accepts the report when high together with rpt_valid
- rpt_min  out  WIDTH  minimum width in the window
- rpt_max  out  WIDTH  maximum width in the window
- rpt_sum  out  WIDTH+WINDOW_LOG2  exact sum of widths in the window
- rpt_avg  out  WIDTH  rpt_sum >> WINDOW_LOG2 (truncating)
- rpt_oor  out  WINDOW_LOG2+1  count of out-of-range samples in the window
- overrun  out  1  sticky: a report was overwritten before acceptance
- fill  out  WINDOW_LOG2+1  samples currently in the open window

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All outputs and internal registers are 0. The accumulator state machine enters EMPTY.
- Sample: a sample is taken in any cycle where pulse_done=1 and enable=1. Back-to-back pulse_done cycles each count as one sample.
- Accumulator FSM:
  - EMPTY: on a sample, acc_min=acc_max=acc_sum=sample, fill=1, go to ACCUM. If window size is 1, close immediately instead.
  - ACCUM: on a sample, acc_min=min(acc_min,x), acc_max=max(acc_max,x), acc_sum+=x, fill+=1, acc_oor+=out-of-range(x).
  - Window close: the sample that makes fill reach 2^WINDOW_LOG2 closes the window.
- Close: on the closing cycle, the snapshot (including the closing sample) loads the report slot. On the next cycle rpt_valid=1, and the FSM returns to EMPTY with fill=0.
- Latency: closing sample to rpt_valid is 1 cycle.
- Arithmetic: acc_sum is WIDTH+WINDOW_LOG2 bits and cannot overflow. rpt_avg is computed from the registered sum, so it is valid in the same cycle as rpt_valid.
- Report handshake:
  - The report fields are stable while rpt_valid=1 and rpt_ready=0.
  - The transfer occurs on a cycle with rpt_valid & rpt_ready; rpt_valid drops the next cycle unless a new close happens in the same cycle.
  - Sampling never stalls, and accumulation of the next window continues during backpressure.
- Overrun: a close while rpt_valid=1 and no transfer in that cycle overwrites the slot with the new report and sets overrun (sticky). A close in the same cycle as a transfer is not an overrun; rpt_valid stays 1 with the new data.
- clear:
  - Resets the accumulators, fill, the report slot (rpt_valid=0) and overrun. FSM goes to EMPTY.
  - clear has priority over a simultaneous sample (the sample is discarded) and over a simultaneous close.
- enable=0: samples are ignored. Accumulator contents, fill and the report slot are held, and handshakes continue.
- Reset mid-window or mid-report: everything returns to reset values and the pending report is lost; no partial report is ever emitted.

Decomposition:
- Shared package pws_pkg:
  - accumulator state enum (EMPTY, ACCUM);
  - report struct (min, max, sum, avg, oor);
  - function sum_width(WIDTH, WINDOW_LOG2).
- One natural sub-module, pws_report_slot: a single-entry holding register with the valid/ready handshake and overrun detection.
- Everything else stays in pulse_width_stats.

Test Plan:
- WINDOW_LOG2=2, widths 10, 20, 30, 40 with rpt_ready=1 → one cycle after the 4th strobe: rpt_valid=1, min=10, max=40, sum=100, avg=25, fill=0.
- WINDOW_LOG2=2, widths 5, 6, 7, 9 → sum=27, avg=6 (truncated). Widths all 0xFFFFFFFF → sum=0x3FFFFFFFC, avg=0xFFFFFFFF.
- rpt_ready=0, two full windows (1,1,1,1 then 2,2,2,2) → report fields show min=max=2, overrun=1, rpt_valid held. rpt_ready=1 then clears rpt_valid, and overrun stays 1.
- Transfer and close in the same cycle → overrun=0, rpt_valid stays 1, new data is presented.
- clear asserted with pulse_done after 2 samples → fill=0, the sample is dropped, and the next 4 samples produce a report from those 4 only.
- LIMIT_LO=10, LIMIT_HI=100, widths 5, 50, 150, 60 → rpt_oor=2. reset_n low during rpt_valid → all outputs 0 immediately.

Source files
------------

// File: rtl/pws_pkg.sv
// Shared types and helpers for the pulse-width statistics block.
package pws_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    localparam int MAX_WINDOW_LOG2 = 8;

    // A window sum needs WINDOW_LOG2 guard bits above the sample width.
    function automatic int sum_width(input int width, input int window_log2);
        return width + window_log2;
    endfunction

endpackage

// File: rtl/pws_if.sv
// Measurement input and statistics report handshake of pulse_width_stats.
interface pws_if
    import pws_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int WINDOW_LOG2 = 3
) ();

    logic [WIDTH-1:0]                           pulse_width;
    logic                                       pulse_done;
    logic                                       rpt_valid;
    logic                                       rpt_ready;
    logic [WIDTH-1:0]                           rpt_min;
    logic [WIDTH-1:0]                           rpt_max;
    logic [sum_width(WIDTH, WINDOW_LOG2)-1:0]   rpt_sum;
    logic [WIDTH-1:0]                           rpt_avg;
    logic [WINDOW_LOG2:0]                       rpt_oor;

    // Environment side: detector plus telemetry consumer.
    modport master (
        output pulse_width, pulse_done, rpt_ready,
        input  rpt_valid, rpt_min, rpt_max, rpt_sum, rpt_avg, rpt_oor
    );

    // Statistics block side.
    modport slave (
        input  pulse_width, pulse_done, rpt_ready,
        output rpt_valid, rpt_min, rpt_max, rpt_sum, rpt_avg, rpt_oor
    );

endinterface

// File: rtl/pws_report_slot.sv
// Single-entry report register with valid/ready handshake and sticky overrun.
module pws_report_slot #(
    parameter type payload_t = logic
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     clear,
    input  logic     load,
    input  payload_t load_data,
    input  logic     ready,
    output logic     valid,
    output payload_t data,
    output logic     overrun
);

    logic     valid_q, valid_d;
    logic     overrun_q, overrun_d;
    payload_t data_q, data_d;

    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        if (clear) begin
            valid_d   = 1'b0;
            data_d    = '0;
            overrun_d = 1'b0;
        end else if (load) begin
            // A load alongside a transfer replaces the report cleanly.
            data_d  = load_data;
            valid_d = 1'b1;
            if (valid_q && !ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the payload register is reset too, so no stale report is visible after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid   = valid_q;
    assign data    = data_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/pulse_width_stats.sv
// Accumulates min/max/sum/out-of-range count over a window of pulse widths
// and hands one report per window to the telemetry layer.
module pulse_width_stats
    import pws_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               WINDOW_LOG2 = 3,
    parameter logic [WIDTH-1:0] LIMIT_LO    = '0,
    parameter logic [WIDTH-1:0] LIMIT_HI    = '1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 enable,
    pws_if.slave                 bus,
    output logic                 overrun,
    output logic [WINDOW_LOG2:0] fill
);

    localparam int SW     = sum_width(WIDTH, WINDOW_LOG2);
    localparam int FW     = WINDOW_LOG2 + 1;
    localparam int WINDOW = 1 << WINDOW_LOG2;

    typedef struct packed {
        logic [WIDTH-1:0] min;
        logic [WIDTH-1:0] max;
        logic [SW-1:0]    sum;
        logic [WIDTH-1:0] avg;
        logic [FW-1:0]    oor;
    } report_t;

    acc_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_min_q, acc_min_d;
    logic [WIDTH-1:0] acc_max_q, acc_max_d;
    logic [SW-1:0]    acc_sum_q, acc_sum_d;
    logic [FW-1:0]    acc_oor_q, acc_oor_d;
    logic [FW-1:0]    fill_q, fill_d;

    logic             sample, closing, lo_viol, hi_viol;
    logic [WIDTH-1:0] x, upd_min, upd_max;
    logic [SW-1:0]    upd_sum;
    logic [FW-1:0]    upd_oor, upd_fill;
    report_t          snap, rpt;

    assign x = bus.pulse_width;

    // Limits at the ends of the range can never be violated; skip the compare.
    if (LIMIT_LO == '0) begin : g_no_lo
        assign lo_viol = 1'b0;
    end else begin : g_lo
        assign lo_viol = x < LIMIT_LO;
    end
    if (LIMIT_HI == '1) begin : g_no_hi
        assign hi_viol = 1'b0;
    end else begin : g_hi
        assign hi_viol = x > LIMIT_HI;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sample = bus.pulse_done & enable;
        if (state_q == EMPTY) begin
            upd_min  = x;
            upd_max  = x;
            upd_sum  = SW'(x);
            upd_oor  = FW'(lo_viol | hi_viol);
            upd_fill = FW'(1);
        end else begin
            upd_min  = (x < acc_min_q) ? x : acc_min_q;
            upd_max  = (x > acc_max_q) ? x : acc_max_q;
            upd_sum  = acc_sum_q + SW'(x);
            upd_oor  = acc_oor_q + FW'(lo_viol | hi_viol);
            upd_fill = fill_q + FW'(1);
        end
        closing = sample && (upd_fill == FW'(WINDOW));

        snap.min = upd_min;
        snap.max = upd_max;
        snap.sum = upd_sum;
        snap.avg = upd_sum[SW-1:WINDOW_LOG2];
        snap.oor = upd_oor;

        state_d   = state_q;
        acc_min_d = acc_min_q;
        acc_max_d = acc_max_q;
        acc_sum_d = acc_sum_q;
        acc_oor_d = acc_oor_q;
        fill_d    = fill_q;
        if (clear || closing) begin
            state_d   = EMPTY;
            acc_min_d = '0;
            acc_max_d = '0;
            acc_sum_d = '0;
            acc_oor_d = '0;
            fill_d    = '0;
        end else if (sample) begin
            state_d   = ACCUM;
            acc_min_d = upd_min;
            acc_max_d = upd_max;
            acc_sum_d = upd_sum;
            acc_oor_d = upd_oor;
            fill_d    = upd_fill;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            acc_min_q <= '0;
            acc_max_q <= '0;
            acc_sum_q <= '0;
            acc_oor_q <= '0;
            fill_q    <= '0;
        end else begin
            state_q   <= state_d;
            acc_min_q <= acc_min_d;
            acc_max_q <= acc_max_d;
            acc_sum_q <= acc_sum_d;
            acc_oor_q <= acc_oor_d;
            fill_q    <= fill_d;
        end
    end

    pws_report_slot #(
        .payload_t (report_t)
    ) u_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .load      (closing),
        .load_data (snap),
        .ready     (bus.rpt_ready),
        .valid     (bus.rpt_valid),
        .data      (rpt),
        .overrun   (overrun)
    );

    assign bus.rpt_min = rpt.min;
    assign bus.rpt_max = rpt.max;
    assign bus.rpt_sum = rpt.sum;
    assign bus.rpt_avg = rpt.avg;
    assign bus.rpt_oor = rpt.oor;
    assign fill        = fill_q;

endmodule
